// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature encoder emulator:
// Gray-code stepping and symmetric saturating addition.
package quad_pkg;

  typedef logic signed [31:0] wide_t;

  localparam logic [1:0] QUAD_IDLE = 2'b11;

  // dir = 1 walks 00->10->11->01->00, dir = 0 walks the reverse sequence.
  function automatic logic [1:0] quad_next(input logic [1:0] state, input logic dir);
    logic [1:0] nxt;
    case (state)
      2'b00:   nxt = dir ? 2'b10 : 2'b01;
      2'b10:   nxt = dir ? 2'b11 : 2'b00;
      2'b11:   nxt = dir ? 2'b01 : 2'b10;
      default: nxt = dir ? 2'b00 : 2'b11;
    endcase
    return nxt;
  endfunction

  // Clamp to +/-(2^(acc_w-1)-1) so the most negative code is never produced.
  function automatic wide_t sat_add(input wide_t acc, input wide_t delta, input int acc_w);
    wide_t lim;
    wide_t sum;
    lim = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    sum = acc + delta;
    if (sum > lim) return lim;
    if (sum < -lim) return -lim;
    return sum;
  endfunction

endpackage

// File: rtl/quad_encoder_chan.sv
// One encoder channel: delta accumulator draining into a Gray AB stream,
// plus a synchronised, edge-divided pass-through of a physical encoder.
module quad_encoder_chan
  import quad_pkg::*;
#(
  parameter int ACC_W   = 12,
  parameter int DELTA_W = 12,
  parameter int RAW_DIV = 1
) (
  input  logic                      clk_12m,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      delta_valid,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                      delta_set,
  input  logic                      raw_a,
  input  logic                      raw_b,
  output logic [1:0]                enc,
  output logic                      busy,
  output logic                      raw_active
);

  localparam int CNT_W = (RAW_DIV > 1) ? $clog2(RAW_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAW_DIV - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [1:0]              emu_q;
  logic [1:0]              raw_q;
  logic [1:0]              sync_p0;
  logic [1:0]              sync_p1;
  logic [1:0]              sync_prev;
  logic [CNT_W-1:0]        edge_cnt;
  logic                    step_due;
  logic                    a_edge;
  wide_t                   tick_step;
  wide_t                   sum;

  assign step_due = tick && (acc != '0);
  assign a_edge   = sync_p1[1] ^ sync_prev[1];

  // In set mode a step due on this tick is still emitted, but its decrement is dropped.
  always_comb begin
    tick_step = '0;
    sum       = '0;
    if (step_due) tick_step = acc[ACC_W-1] ? -wide_t'(1) : wide_t'(1);
    if (delta_valid) begin
      if (delta_set) sum = sat_add(wide_t'(delta), '0, ACC_W);
      else           sum = sat_add(wide_t'(acc), wide_t'(delta) - tick_step, ACC_W);
    end else begin
      sum = wide_t'(acc) - tick_step;
    end
    acc_next = ACC_W'(sum);
  end

  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      busy       <= 1'b0;
      emu_q      <= QUAD_IDLE;
      raw_q      <= QUAD_IDLE;
      raw_active <= 1'b0;
      sync_p0    <= QUAD_IDLE;
      sync_p1    <= QUAD_IDLE;
      sync_prev  <= QUAD_IDLE;
      edge_cnt   <= '0;
    end else begin
      acc  <= acc_next;
      busy <= (acc_next != '0);
      if (step_due) emu_q <= quad_next(emu_q, ~acc[ACC_W-1]);

      sync_p0   <= {raw_a, raw_b};
      sync_p1   <= sync_p0;
      sync_prev <= sync_p1;

      // Direction comes from A^B after the edge: 1 walks the reverse sequence.
      if (a_edge) begin
        if (edge_cnt == CNT_LAST) begin
          edge_cnt <= '0;
          raw_q    <= quad_next(raw_q, ~^sync_p1);
        end else begin
          edge_cnt <= edge_cnt + 1'b1;
        end
      end

      if (sync_p1 != sync_prev) raw_active <= 1'b1;
      else if (delta_valid)     raw_active <= 1'b0;
    end
  end

  assign enc = raw_active ? raw_q : emu_q;

endmodule

// File: rtl/quad_encoder_emu.sv
// Multi-channel quadrature encoder emulator: a shared step-rate tick
// feeding CHANNELS independent encoder channels.
module quad_encoder_emu
  import quad_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 12,
  parameter int DELTA_W     = 12,
  parameter int STEP_PERIOD = 3000,
  parameter int RAW_DIV     = 1
) (
  input  logic                          clk_12m,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           delta_valid,
  input  logic [CHANNELS*DELTA_W-1:0]   delta,
  input  logic [CHANNELS-1:0]           delta_set,
  input  logic [CHANNELS-1:0]           raw_a,
  input  logic [CHANNELS-1:0]           raw_b,
  output logic [2*CHANNELS-1:0]         enc,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           raw_active
);

  localparam int STEP_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIOD - 1);

  logic [STEP_W-1:0] step_cnt;
  logic              tick;

  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset)    step_cnt <= '0;
    else if (tick) step_cnt <= '0;
    else           step_cnt <= step_cnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    quad_encoder_chan #(
      .ACC_W   (ACC_W),
      .DELTA_W (DELTA_W),
      .RAW_DIV (RAW_DIV)
    ) u_chan (
      .clk_12m     (clk_12m),
      .reset       (reset),
      .tick        (tick),
      .delta_valid (delta_valid[i]),
      .delta       (delta[i*DELTA_W +: DELTA_W]),
      .delta_set   (delta_set[i]),
      .raw_a       (raw_a[i]),
      .raw_b       (raw_b[i]),
      .enc         (enc[2*i +: 2]),
      .busy        (busy[i]),
      .raw_active  (raw_active[i])
    );
  end

endmodule
